// File: rtl/vga_img_top_if.sv
// ---------------------------------------------------------------------------
// vga_img_top_if : video DAC output bundle for the VGA pattern generator.
//   hsync, vsync : active-low sync pulses
//   sync         : DAC composite sync (always 0 from the generator)
//   vga_r/g/b    : 8-bit colour channels
//   vga_blk      : 1 while an active pixel is being displayed
//   vga_clk      : DAC pixel clock (inverted system clock)
// Modports: master = generator side (drives), slave = DAC side (receives).
// ---------------------------------------------------------------------------
interface vga_img_top_if;
  logic       hsync;
  logic       vsync;
  logic       sync;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_blk;
  logic       vga_clk;

  modport master (output hsync, vsync, sync, vga_r, vga_g, vga_b, vga_blk, vga_clk);
  modport slave  (input  hsync, vsync, sync, vga_r, vga_g, vga_b, vga_blk, vga_clk);
endinterface

// File: rtl/vga_img_top.sv
// ---------------------------------------------------------------------------
// vga_img_top : VGA 640x480@60 Hz timing and 8-bar colour pattern generator.
// Ports:
//   clk   : 25 MHz pixel clock
//   rst_n : asynchronous reset, active HIGH (name kept from the codebase)
//   vid   : vga_img_top_if.master - sync, blanking, RGB and DAC clock outputs
// All video outputs are registered one cycle after the h/v counter state
// they describe, so sync, blanking and colour stay mutually aligned.
// Optional build macro VGA_BORDER_EN: draws a one-pixel white frame around
// the active area on top of the bar pattern.
// ---------------------------------------------------------------------------
module vga_img_top #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int BAR_W    = 80
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_img_top_if.master vid
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [HW-1:0] BAR_DIV    = HW'(BAR_W);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blk_q,   blk_d;
  logic [23:0]   data_dis, data_dis_d;
  logic          active;
  logic [HW-1:0] x_pos;
`ifdef VGA_BORDER_EN
  localparam logic [HW-1:0] X_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] Y_LAST = VW'(V_ACTIVE - 1);
  logic [VW-1:0] y_pos;
`endif

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = 24'hFF0000;
      3'd1:    bar_colour = 24'h00FF00;
      3'd2:    bar_colour = 24'h0000FF;
      3'd3:    bar_colour = 24'hFFFF00;
      3'd4:    bar_colour = 24'h00FFFF;
      3'd5:    bar_colour = 24'hFF00FF;
      3'd6:    bar_colour = 24'hC0C0C0;
      default: bar_colour = 24'hFFFFFF;
    endcase
  endfunction

  // Stage 0: counter state -> next counters and the output values it implies
  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    // The line counter only moves on the last pixel of a line.
    if (h_cnt_q == H_LAST)
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);

    active  = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
              (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    x_pos   = h_cnt_q - H_ACT_BEG;
    hsync_d = !(h_cnt_q < H_SYNC_END);
    vsync_d = !(v_cnt_q < V_SYNC_END);
    blk_d   = active;

    data_dis_d = 24'h000000;
    if (active)
      data_dis_d = bar_colour(3'(x_pos / BAR_DIV));
`ifdef VGA_BORDER_EN
    y_pos = v_cnt_q - V_ACT_BEG;
    if (active && (x_pos == '0 || x_pos == X_LAST || y_pos == '0 || y_pos == Y_LAST))
      data_dis_d = 24'hFFFFFF;
`endif
  end

  // Stage 1: registered counters and outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      blk_q    <= 1'b0;
      data_dis <= 24'h000000;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      blk_q    <= blk_d;
      data_dis <= data_dis_d;
    end
  end

  assign vid.hsync   = hsync_q;
  assign vid.vsync   = vsync_q;
  assign vid.sync    = 1'b0;
  assign vid.vga_blk = blk_q;
  assign vid.vga_r   = data_dis[23:16];
  assign vid.vga_g   = data_dis[15:8];
  assign vid.vga_b   = data_dis[7:0];
  // Inverted clock lets the DAC latch in the middle of each pixel.
  assign vid.vga_clk = ~clk;

endmodule

// File: tb/tb_vga_img_top.sv
// ---------------------------------------------------------------------------
// tb_vga_img_top : self-checking bench for vga_img_top.
// A full-size instance is checked against a position-based frame model
// for the first ~36 lines (twice, around a mid-line reset), plus literal
// probes of timing and bar colours. A second, scaled-down instance is run
// through many complete frames to check frame period and vsync width.
// ---------------------------------------------------------------------------
module tb_vga_img_top;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #20 clk = ~clk;

  vga_img_top_if vif();
  vga_img_top_if vifs();

  vga_img_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif)
  );

  vga_img_top #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(16), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(4),  .V_FRONT(1),
    .BAR_W(2)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vifs)
  );

  localparam logic [23:0] PAL [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                                      24'h00FFFF, 24'hFF00FF, 24'hC0C0C0, 24'hFFFFFF};

  int errors = 0;
  int checks = 0;
  int n;  // clock edges since reset release

  always @(posedge clk or posedge rst_n)
    if (rst_n) n <= 0;
    else       n <= n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", nm, act, exp, n);
    end
  endtask

  // Outputs expected for raster position p (pixels since frame start):
  // {hsync, vsync, blk, rgb[23:0]}
  function automatic logic [26:0] model(input int p, input int hs, input int hb, input int ha,
                                        input int hf, input int vs, input int vb, input int va,
                                        input int vf, input int bw);
    int ht, vt, h, v, x, y;
    logic act;
    logic [23:0] rgb;
    ht  = hs + hb + ha + hf;
    vt  = vs + vb + va + vf;
    h   = p % ht;
    v   = (p / ht) % vt;
    x   = h - hs - hb;
    y   = v - vs - vb;
    act = (x >= 0) && (x < ha) && (y >= 0) && (y < va);
    rgb = act ? PAL[x / bw] : 24'h0;
`ifdef VGA_BORDER_EN
    if (act && (x == 0 || x == ha - 1 || y == 0 || y == va - 1)) rgb = 24'hFFFFFF;
`endif
    return {h >= hs, v >= vs, act, rgb};
  endfunction

  // Hand-written bar colours for probe points on line y=1.
  function automatic logic [23:0] lit_bar(input int x);
    case (x)
`ifdef VGA_BORDER_EN
      0:   return 24'hFFFFFF;
`else
      0:   return 24'hFF0000;
`endif
      1, 40, 79: return 24'hFF0000;
      80, 120:   return 24'h00FF00;
      200:       return 24'h0000FF;
      280:       return 24'hFFFF00;
      360:       return 24'h00FFFF;
      440:       return 24'hFF00FF;
      520:       return 24'hC0C0C0;
      default:   return 24'hFFFFFF;  // 600, 639
    endcase
  endfunction

  // Per-cycle compare plus edge measurements, sampled on the falling edge.
  initial begin : monitor
    logic [26:0] e, es;
    int p, h, v, x;
    logic prev_hs, prev_vs, prev_vss;
    int hs_fall, vs_fall, vss_fall, blk_cnt;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_vss = 1'b1;
    hs_fall = -1; vs_fall = -1; vss_fall = -1; blk_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n || n == 0) begin
        e  = {1'b1, 1'b1, 1'b0, 24'h0};
        es = e;
      end else begin
        e  = model(n - 1, 96, 48, 640, 16, 2, 33, 480, 10, 80);
        es = model(n - 1, 4, 3, 16, 2, 2, 2, 4, 1, 2);
      end
      chk("video_full", {vif.hsync, vif.vsync, vif.vga_blk, vif.vga_r, vif.vga_g, vif.vga_b}, 32'(e));
      chk("data_dis", dut.data_dis, e[23:0]);
      chk("sync_clk", {vif.sync, vif.vga_clk}, 2'b01);
      chk("video_small", {vifs.hsync, vifs.vsync, vifs.vga_blk, vifs.vga_r, vifs.vga_g, vifs.vga_b}, 32'(es));

      if (rst_n) begin
        prev_hs = 1'b1; prev_vs = 1'b1; prev_vss = 1'b1;
        hs_fall = -1; vs_fall = -1; vss_fall = -1; blk_cnt = 0;
      end else begin
        // hsync period / width and active pixels per line
        if (prev_hs && !vif.hsync) begin
          if (hs_fall >= 0) chk("hsync_period", n - hs_fall, 800);
          if (blk_cnt != 0) chk("blk_per_line", blk_cnt, 640);
          blk_cnt = 0;
          hs_fall = n;
        end
        if (!prev_hs && vif.hsync && hs_fall >= 0) chk("hsync_low", n - hs_fall, 96);
        if (vif.vga_blk) blk_cnt++;
        prev_hs = vif.hsync;
        // vsync first fall and width
        if (prev_vs && !vif.vsync) begin
          if (vs_fall < 0) chk("vsync_first_fall", n, 1);
          vs_fall = n;
        end
        if (!prev_vs && vif.vsync && vs_fall >= 0) chk("vsync_low", n - vs_fall, 1600);
        prev_vs = vif.vsync;
        // scaled instance: frame period (25*9) and vsync width (2*25)
        if (prev_vss && !vifs.vsync) begin
          if (vss_fall >= 0) chk("small_frame_period", n - vss_fall, 225);
          vss_fall = n;
        end
        if (!prev_vss && vifs.vsync && vss_fall >= 0) chk("small_vsync_low", n - vss_fall, 50);
        prev_vss = vifs.vsync;

        // literal probes
        if (n > 0) begin
          p = n - 1; h = p % 800; v = p / 800; x = h - 144;
          if (v == 36 && (h == 143 || h == 784))
            chk("probe_blank", {vif.vga_blk, vif.vga_r, vif.vga_g, vif.vga_b}, 25'h0);
          if (v == 36 && x >= 0 && x < 640 &&
              ((x % 80) == 40 || x == 0 || x == 1 || x == 79 || x == 80 || x == 639))
            chk("probe_bar", dut.data_dis, lit_bar(x));
          if (v == 35 && h == 145)
`ifdef VGA_BORDER_EN
            chk("probe_top_row", dut.data_dis, 24'hFFFFFF);
`else
            chk("probe_top_row", dut.data_dis, 24'hFF0000);
`endif
          if (v == 34 && h == 400) chk("probe_vblank", vif.vga_blk, 1'b0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_hsync", vif.hsync, 1'b1);
    chk("rst_vsync", vif.vsync, 1'b1);
    chk("rst_blk",   vif.vga_blk, 1'b0);
    chk("rst_rgb",   {vif.vga_r, vif.vga_g, vif.vga_b}, 24'h0);
    repeat (10) @(posedge clk);
    #5 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("first_hsync", vif.hsync, 1'b0);
    chk("first_vsync", vif.vsync, 1'b0);

    // run into line 36, then reset in the middle of its active region
    repeat (36 * 800 + 300) @(posedge clk);
    #5 rst_n = 1'b1;
    #1;
    chk("async_hsync", vif.hsync, 1'b1);
    chk("async_vsync", vif.vsync, 1'b1);
    chk("async_blk",   vif.vga_blk, 1'b0);
    chk("async_rgb",   {vif.vga_r, vif.vga_g, vif.vga_b}, 24'h0);
    chk("async_data",  dut.data_dis, 24'h0);
    chk("vga_clk_hi_phase", vif.vga_clk, 1'b0);
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b0;

    repeat (30000) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
